// File: rtl/osc_capture_ctrl_if.sv
// Control, sample and readout signals of the oscilloscope capture controller.
// master = stimulus/host side, slave = osc_capture_ctrl.
interface osc_capture_ctrl_if #(
  parameter int unsigned AW = 8
) ();
  logic          arm;
  logic          abort;
  logic [7:0]    trig_level;
  logic [AW-1:0] pre_len;
  logic [7:0]    sample;
  logic          sample_vld;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [2:0]    state;
  logic          done;

  modport master (
    output arm, abort, trig_level, pre_len, sample, sample_vld, tx_ready,
    input  tx_data, tx_valid, state, done
  );

  modport slave (
    input  arm, abort, trig_level, pre_len, sample, sample_vld, tx_ready,
    output tx_data, tx_valid, state, done
  );
endinterface

// File: rtl/osc_capture_ctrl.sv
// Triggered circular-buffer sample capture with pre-trigger history and
// oldest-first byte readout over a valid/ready stream.
module osc_capture_ctrl #(
  parameter int unsigned DEPTH = 256
) (
  input logic               clk,
  input logic               rst_n,
  osc_capture_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_READ  = 3'd4
  } state_e;

  state_e state_q, state_n;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_q;
  logic [7:0]    trig_q, trig_n;
  logic [AW-1:0] pre_q, pre_n;
  logic [AW-1:0] wptr_q, wptr_n;
  logic [AW-1:0] rptr_q, rptr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [7:0]    prev_q, prev_n;
  logic          prev_ok_q, prev_ok_n;
  logic          fetched_q, fetched_n;
  logic [7:0]    tx_data_q, tx_data_n;
  logic          tx_valid_q, tx_valid_n;
  logic          done_q, done_n;

  logic          wr_en_c;
  logic          trigger_c;
  logic          accept_c;
  logic          load_c;
  logic [CW-1:0] post_len_c;
  logic [CW-1:0] cnt_inc_c;

  assign post_len_c = DEPTH_C - CW'(pre_q);
  assign cnt_inc_c  = cnt_q + CW'(1);
  assign trigger_c  = (state_q == S_ARMED) && bus.sample_vld && prev_ok_q &&
                      (prev_q < trig_q) && (bus.sample >= trig_q);
  assign accept_c   = tx_valid_q && bus.tx_ready;
  // rd_q is only trusted one cycle after rptr settles; cnt counts bytes loaded.
  assign load_c     = (state_q == S_READ) && fetched_q &&
                      (!tx_valid_q || bus.tx_ready) && (cnt_q != DEPTH_C);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_n;
  end

  // Next-state logic; abort overrides every other event
  always_comb begin
    state_n = state_q;
    if (bus.abort) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus.arm) state_n = (bus.pre_len == '0) ? S_ARMED : S_PRE;
        S_PRE:   if (bus.sample_vld && (cnt_inc_c == CW'(pre_q))) state_n = S_ARMED;
        S_ARMED: if (trigger_c) state_n = (post_len_c == CW'(1)) ? S_READ : S_POST;
        S_POST:  if (bus.sample_vld && (cnt_inc_c == post_len_c)) state_n = S_READ;
        S_READ:  if (accept_c && (cnt_q == DEPTH_C)) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Datapath / output next values
  always_comb begin
    trig_n     = trig_q;
    pre_n      = pre_q;
    wptr_n     = wptr_q;
    rptr_n     = rptr_q;
    cnt_n      = cnt_q;
    prev_n     = prev_q;
    prev_ok_n  = prev_ok_q;
    fetched_n  = fetched_q;
    tx_data_n  = tx_data_q;
    tx_valid_n = tx_valid_q;
    done_n     = 1'b0;
    wr_en_c    = 1'b0;
    if (bus.abort) begin
      tx_valid_n = 1'b0;
      fetched_n  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            trig_n    = bus.trig_level;
            pre_n     = bus.pre_len;
            wptr_n    = '0;
            rptr_n    = '0;
            cnt_n     = '0;
            prev_ok_n = 1'b0;
          end
        end
        S_PRE, S_ARMED: begin
          if (bus.sample_vld) begin
            wr_en_c   = 1'b1;
            wptr_n    = wptr_q + AW'(1);
            prev_n    = bus.sample;
            prev_ok_n = 1'b1;
            if (state_q == S_PRE) begin
              cnt_n = cnt_inc_c;
            end else if (trigger_c) begin
              cnt_n = CW'(1);
              if (post_len_c == CW'(1)) begin
                rptr_n    = wptr_q + AW'(1);
                cnt_n     = '0;
                fetched_n = 1'b0;
              end
            end
          end
        end
        S_POST: begin
          if (bus.sample_vld) begin
            wr_en_c = 1'b1;
            wptr_n  = wptr_q + AW'(1);
            cnt_n   = cnt_inc_c;
            // Position after the final write is the oldest sample in the buffer
            if (cnt_inc_c == post_len_c) begin
              rptr_n    = wptr_q + AW'(1);
              cnt_n     = '0;
              fetched_n = 1'b0;
            end
          end
        end
        S_READ: begin
          fetched_n = !load_c;
          if (accept_c) tx_valid_n = 1'b0;
          if (load_c) begin
            tx_data_n  = rd_q;
            tx_valid_n = 1'b1;
            rptr_n     = rptr_q + AW'(1);
            cnt_n      = cnt_inc_c;
          end
          if (accept_c && (cnt_q == DEPTH_C)) done_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q     <= '0;
      pre_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      fetched_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      trig_q     <= trig_n;
      pre_q      <= pre_n;
      wptr_q     <= wptr_n;
      rptr_q     <= rptr_n;
      cnt_q      <= cnt_n;
      prev_q     <= prev_n;
      prev_ok_q  <= prev_ok_n;
      fetched_q  <= fetched_n;
      tx_data_q  <= tx_data_n;
      tx_valid_q <= tx_valid_n;
      done_q     <= done_n;
    end
  end

  // Sample buffer: contents are never reset, read is registered
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wptr_q] <= bus.sample;
    rd_q <= mem[rptr_q];
  end

  assign bus.state    = state_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.done     = done_q;
endmodule

// File: doc/osc_capture_ctrl.md
OSC_CAPTURE_CTRL -- requirements
Module: osc_capture_ctrl

Interface
REQ-001 Parameter: DEPTH, 256, capture buffer depth in samples (power of 2); AW = log2(DEPTH) = 8.
REQ-002 Port: clk  in  1  single system clock; all logic rising-edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: arm  in  1  single-cycle pulse; starts a capture from IDLE.
REQ-005 Port: abort  in  1  single-cycle pulse; cancels any capture or readout.
REQ-006 Port: trig_level  in  8  unsigned trigger threshold; sampled at arm.
REQ-007 Port: pre_len  in  AW  pre-trigger sample count; sampled at arm.
REQ-008 Port: sample  in  8  unsigned ADC sample.
REQ-009 Port: sample_vld  in  1  sample qualifier; one sample per high cycle.
REQ-010 Port: tx_data  out  8  readout byte to UART transmitter.
REQ-011 Port: tx_valid  out  1  tx_data valid; valid/ready handshake.
REQ-012 Port: tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
REQ-013 Port: state  out  3  current FSM state code (IDLE=0, PRE=1, ARMED=2, POST=3, READ=4).
REQ-014 Port: done  out  1  one-cycle pulse when the last readout byte is accepted.

Function
REQ-015 Internal DEPTH x 8 buffer; write pointer wptr (AW bits) wraps DEPTH-1 -> 0; one write per sample_vld in PRE, ARMED, POST only.
REQ-016 IDLE: arm -> latch trig_level, pre_len; clear wptr, counters, prev_ok; go PRE, or ARMED if pre_len == 0.
REQ-017 PRE: count written samples; after pre_len writes go ARMED; no trigger evaluation in PRE.
REQ-018 ARMED: trigger = sample_vld && prev_ok && prev_sample < trig_level && sample >= trig_level (rising crossing); triggering sample is written and counts as first post sample; go POST.
REQ-019 prev_sample/prev_ok update on every sample_vld in PRE and ARMED; prev_ok cleared on arm.
REQ-020 POST: capture continues until total post samples == DEPTH - pre_len (triggering sample included); then go READ with rptr = wptr (oldest sample).
REQ-021 ARMED with no trigger keeps overwriting circularly; pre-trigger history remains the last pre_len samples before the trigger.
REQ-022 READ: exactly DEPTH bytes output oldest-first, rptr incrementing with wrap; buffer read latency one cycle, absorbed internally.
REQ-023 tx_valid, once high, holds with tx_data stable until tx_ready; no bubble required between accepted bytes beyond one cycle.
REQ-024 On acceptance of byte DEPTH: done pulses 1 cycle, tx_valid low next cycle, go IDLE.
REQ-025 sample_vld ignored in IDLE and READ; arm ignored outside IDLE.
REQ-026 abort in any state -> IDLE next cycle, tx_valid low, done not asserted; abort beats simultaneous arm, trigger, or tx acceptance.
REQ-027 Comparisons unsigned 8-bit; counters AW+1 bits so DEPTH is representable.

Reset
REQ-028 rst_n low: state=IDLE, tx_valid=0, tx_data=0, done=0, wptr=rptr=0, counters=0, prev_ok=0, immediately and regardless of clk.
REQ-029 Buffer contents not reset; never read before fully written in the current capture.
REQ-030 Reset asserted mid-READ or mid-POST: outputs as REQ-028; no partial byte or done after deassertion.

Verification
REQ-031 pre_len=16, trig_level=0x80, ramp 0x00..0xFF repeating, tx_ready=1 -> 256 bytes out, byte 16 = 0x80, byte 15 = 0x7F, done once.
REQ-032 pre_len=0, trig 0x40 -> ARMED directly; first output byte is the trigger sample >= 0x40 preceded in stream by nothing.
REQ-033 Constant 0x90 input, trig 0x80 -> no trigger, stays ARMED; abort -> IDLE next cycle, tx_valid=0.
REQ-034 READ with tx_ready toggling 1 cycle on / 3 off -> tx_data stable while stalled, all 256 bytes in order, no duplicates.
REQ-035 Sample equal to trig_level after sample below it triggers; sample at level after sample at level does not.
REQ-036 rst_n pulled low during READ byte 100 -> tx_valid=0, state=0 asynchronously; new arm then completes normally.
